// File: rtl/mem_arb_pkg.sv
// Shared TinyRV1 definitions: requester IDs and memory request types used by
// the memory arbiter and its tag FIFO.
package mem_arb_pkg;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_t;

    typedef enum logic {
        MEMREQ_READ  = 1'b0,
        MEMREQ_WRITE = 1'b1
    } memreq_type_t;

    localparam int unsigned REQ_ID_W = 1;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;

    // Round-robin helper: the requester that did not win last time.
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
    endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Small in-order tag FIFO recording which requester owns each outstanding
// memory request; a pop and a push may share a cycle, even when full.
module tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_arb.sv
// Two-requester (fetch/data) round-robin arbiter onto one in-order memory
// port; a tag FIFO routes each response back to the requester that issued it.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    input  logic [ADDR_W-1:0] imemreq_addr,
    output logic              imemresp_val,
    output logic [DATA_W-1:0] imemresp_data,

    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    input  logic              dmemreq_type,
    input  logic [ADDR_W-1:0] dmemreq_addr,
    input  logic [DATA_W-1:0] dmemreq_wdata,
    output logic              dmemresp_val,
    output logic [DATA_W-1:0] dmemresp_data,

    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic              memreq_type,
    output logic [ADDR_W-1:0] memreq_addr,
    output logic [DATA_W-1:0] memreq_wdata,
    input  logic              memresp_val,
    input  logic [DATA_W-1:0] memresp_data
);

    req_id_t             last_grant;
    req_id_t             grant;
    req_id_t             head_id;
    logic [REQ_ID_W-1:0] head_bits;
    logic [REQ_ID_W-1:0] push_bits;
    logic                fifo_full;
    logic                fifo_empty;
    logic                can_issue;
    logic                xfer;
    logic                pop;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = REQ_IMEM;
        if (imemreq_val && dmemreq_val)
            grant = other_req(last_grant);
        else if (dmemreq_val)
            grant = REQ_DMEM;
    end

    // When full, a response popping this cycle frees the slot we push into.
    assign can_issue  = !fifo_full || memresp_val;
    assign memreq_val = !rst && (imemreq_val || dmemreq_val) && can_issue;
    assign xfer       = memreq_val && memreq_rdy;

    assign imemreq_rdy = memreq_val && (grant == REQ_IMEM) && memreq_rdy;
    assign dmemreq_rdy = memreq_val && (grant == REQ_DMEM) && memreq_rdy;

    always_comb begin
        memreq_type  = MEMREQ_READ;
        memreq_addr  = '0;
        memreq_wdata = '0;
        if (memreq_val) begin
            if (grant == REQ_DMEM) begin
                memreq_type  = dmemreq_type;
                memreq_addr  = dmemreq_addr;
                memreq_wdata = dmemreq_wdata;
            end else begin
                memreq_addr  = imemreq_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= REQ_DMEM;
        else if (xfer)
            last_grant <= grant;
    end

    assign push_bits = grant;
    assign head_id   = req_id_t'(head_bits);
    // A response with no outstanding tag is dropped rather than misrouted.
    assign pop       = !rst && memresp_val && !fifo_empty;

    tag_fifo #(
        .WIDTH (REQ_ID_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (push_bits),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_bits)
    );

    assign imemresp_val  = pop && (head_id == REQ_IMEM);
    assign dmemresp_val  = pop && (head_id == REQ_DMEM);
    assign imemresp_data = imemresp_val ? memresp_data : '0;
    assign dmemresp_data = dmemresp_val ? memresp_data : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(memresp_val && fifo_empty))
                else $warning("mem_arb: memresp_val with no outstanding request ignored");
        end
    end

endmodule
